softmax_row_feeder: RTL and testbench
=====================================

Name: softmax_row_feeder

Overview:
- Upstream front end of the Q8.8 softmax pipeline.
- Accepts a serial stream of signed Q8.8 scores with a valid/ready handshake and packs one row into an N-lane flat vector.
- Tracks the signed running maximum of the row as elements arrive.
- Issues the vector, its maximum and a one-cycle valid pulse in the exact form the N-lane softmax core consumes: x_flat, max_x, valid_out.

Parameters:
- N, 8, lanes per row; must equal the softmax core's N; N >= 2.
- CW, $clog2(N+1), width of count and length fields.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  global stall; when low all state holds; same net as the softmax core's en.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  feeder accepts in_data this cycle.
- in_data  input  16  signed Q8.8 score.
- in_last  input  1  marks the final element of a short row; sampled with in_data.
- valid_out  output  1  one-cycle pulse: x_flat, max_x and row_len are valid.
- x_flat  output  N*16  lane i at bits [i*16 +: 16]; element i of the row.
- max_x  output  16  signed maximum of the accepted elements of the row.
- row_len  output  CW  number of real, non-pad elements in the issued row (1..N).

Behaviour:
- Reset (rst low, asynchronous):
  - state=FILL, count=0.
  - valid_out=0, x_flat=0, max_x=0, row_len=0.
  - Running max register=16'h8000.
  - A partial row is discarded; no issue follows reset.
- States: FILL, ISSUE.
- in_ready = en & (state==FILL). Accept = in_valid & in_ready.
- FILL, on accept:
  - Write in_data into lane buffer[count].
  - Running max <= signed max(running max, in_data). A signed comparison is mandatory: 16'hFF00 (-1.0) < 16'h0100 (+1.0).
  - count <= count+1.
  - If in_last=1 or count==N-1: go to ISSUE and latch row_len=count+1.
- FILL, no accept: hold.
- ISSUE, en=1:
  - One cycle. valid_out=1.
  - x_flat = buffer; lanes >= row_len are driven 16'h8000 (most negative Q8.8), so their exp term is ~0.
  - max_x = the updated max, including the final element.
  - Next state FILL; count=0; running max=16'h8000.
  - in_ready=0 during ISSUE, giving one bubble per row. Throughput is row_len+1 cycles per row.
- ISSUE, en=0: stay in ISSUE with valid_out=0; the pulse is emitted on the first cycle en returns high.
- valid_out is combinational from state & en, or registered with identical timing; it is never high on two consecutive cycles.
- x_flat, max_x and row_len are registered at the transition into ISSUE. They hold stable after the pulse until the next issue.
- in_last on the N-th element: normal full row, row_len=N.
- in_last absent after N elements: the row issues anyway, and the next element starts a new row.
- in_valid while in_ready=0: ignored and not consumed. The source must hold data.
- A single-element row (in_last on the first element): row_len=1, max_x=that element, lanes 1..N-1=16'h8000.
- Equal elements: max_x equals that value. 16'h8000 as real data is legal; max_x=16'h8000.
- en=0 mid-FILL: count, buffer and max frozen; no accepts.
- No overflow is possible: at most N elements are written per row.

Test Plan:
- N=8. Reset, then stream 8 elements 0x0100, 0xFF00, 0x0280, 0x0000, 0xFE00, 0x0040, 0x0200, 0x0010 with in_valid held -> one valid_out pulse in the cycle after the 8th accept; x_flat lanes match in order; max_x=0x0280; row_len=8; in_ready=0 in that cycle only.
- Short row 0xFF00, 0xFE80, 0xFF80 with in_last on the 3rd element -> max_x=0xFF80; row_len=3; lanes 3..7=0x8000.
- Mid-row stall: drop en for 4 cycles after element 4, with in_valid held and in_ready=0 -> no extra accept; the row completes normally; drop en during ISSUE -> pulse delayed until en=1, data unchanged.
- Mid-row reset: assert rst low asynchronously after 5 elements -> outputs 0 immediately; the next 8 elements form a fresh row; max_x reflects only the new elements.
- Back-to-back rows: two 8-element rows streamed continuously -> exactly 2 pulses 9 cycles apart; x_flat stays stable between pulses.
- Single element 0x8000 with in_last -> max_x=0x8000; row_len=1; all lanes=0x8000.

Source files
------------

// File: rtl/softmax_row_feeder.sv
// Packs a serial valid/ready stream of signed Q8.8 scores into one N-lane row
// with its signed maximum, in the form the N-lane softmax core consumes.
module softmax_row_feeder #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_data,
  input  logic            in_last,
  output logic            valid_out,
  output logic [N*16-1:0] x_flat,
  output logic [15:0]     max_x,
  output logic [CW-1:0]   row_len
);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [15:0] MOST_NEG = 16'h8000;

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic [15:0]      buf_r [N];
  logic [15:0]      max_r;

  logic             accept_s;
  logic             row_done_s;
  logic [15:0]      max_next_s;
  logic [CW-1:0]    len_next_s;
  logic [N*16-1:0]  flat_next_s;

  function automatic logic [15:0] signed_max(input logic [15:0] a, input logic [15:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign in_ready   = en & (state_r == FILL);
  assign accept_s   = in_valid & in_ready;
  assign valid_out  = en & (state_r == ISSUE);
  assign max_next_s = signed_max(max_r, in_data);
  assign len_next_s = count_r + CW'(1);
  assign row_done_s = in_last | (count_r == CW'(N - 1));

  // Row image as it will be issued: buffered lanes, the arriving element, then padding
  always_comb begin
    flat_next_s = '0;
    for (int i = 0; i < N; i++) begin
      if (CW'(i) < count_r) begin
        flat_next_s[i*16 +: 16] = buf_r[i];
      end else if (CW'(i) == count_r) begin
        flat_next_s[i*16 +: 16] = in_data;
      end else begin
        flat_next_s[i*16 +: 16] = MOST_NEG;
      end
    end
  end

  // Fill/issue sequencer; outputs latch on the transition into ISSUE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= FILL;
      count_r <= '0;
      max_r   <= MOST_NEG;
      x_flat  <= '0;
      max_x   <= 16'h0000;
      row_len <= '0;
      for (int i = 0; i < N; i++) begin
        buf_r[i] <= 16'h0000;
      end
    end else if (en) begin
      case (state_r)
        FILL: begin
          if (accept_s) begin
            for (int i = 0; i < N; i++) begin
              if (CW'(i) == count_r) begin
                buf_r[i] <= in_data;
              end
            end
            count_r <= len_next_s;
            max_r   <= max_next_s;
            if (row_done_s) begin
              state_r <= ISSUE;
              row_len <= len_next_s;
              x_flat  <= flat_next_s;
              max_x   <= max_next_s;
            end
          end
        end
        ISSUE: begin
          state_r <= FILL;
          count_r <= '0;
          max_r   <= MOST_NEG;
        end
        default: begin
          state_r <= FILL;
          count_r <= '0;
          max_r   <= MOST_NEG;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_row_feeder.sv
// Scoreboard bench for softmax_row_feeder: a queue-based row model pushes the
// expected issues, an independent monitor pops them on every valid_out pulse.
module tb_softmax_row_feeder;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_data;
  logic            in_last;
  logic            valid_out;
  logic [N*16-1:0] x_flat;
  logic [15:0]     max_x;
  logic [CW-1:0]   row_len;

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [N*16-1:0] exp_flat_q[$];
  logic [15:0]     exp_max_q[$];
  logic [CW-1:0]   exp_len_q[$];

  // behavioural model state
  logic [15:0]     row_q[$];
  bit              model_issue = 1'b0;
  bit              accepted;
  logic [N*16-1:0] last_flat = '0;
  logic [15:0]     last_max  = 16'h0000;
  logic [CW-1:0]   last_len  = '0;

  int cyc = 0;
  int pulse_count = 0;
  int pulse_cyc = 0;
  int prev_pulse_cyc = 0;
  bit prev_valid = 1'b0;

  softmax_row_feeder #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .valid_out(valid_out),
    .x_flat(x_flat), .max_x(max_x), .row_len(row_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [N*16-1:0] got, input logic [N*16-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Row model: close the row on in_last or on the N-th element
  function automatic void close_row();
    logic [15:0]     m;
    logic [N*16-1:0] f;
    m = row_q[0];
    foreach (row_q[i]) if ($signed(row_q[i]) > $signed(m)) m = row_q[i];
    for (int i = 0; i < N; i++) f[i*16 +: 16] = (i < row_q.size()) ? row_q[i] : 16'h8000;
    exp_flat_q.push_back(f);
    exp_max_q.push_back(m);
    exp_len_q.push_back(CW'(row_q.size()));
    last_flat = f;
    last_max  = m;
    last_len  = CW'(row_q.size());
    row_q.delete();
    model_issue = 1'b1;
  endfunction

  task automatic model_eval();
    bit exp_ready;
    exp_ready = en && !model_issue;
    accepted  = 1'b0;
    check("in_ready", N*16'(in_ready), N*16'(exp_ready));
    check("valid_out", N*16'(valid_out), N*16'(model_issue && en));
    check("x_flat_hold", x_flat, last_flat);
    check("max_x_hold", N*16'(max_x), N*16'(last_max));
    check("row_len_hold", N*16'(row_len), N*16'(last_len));
    if (in_valid && exp_ready) begin
      accepted = 1'b1;
      row_q.push_back(in_data);
      if (in_last || row_q.size() == N) close_row();
    end else if (model_issue && en) begin
      model_issue = 1'b0;
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic e);
    en = e; in_valid = v; in_data = d; in_last = l;
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int budget = 50;
    do begin
      step(1'b1, d, l, 1'b1);
      budget--;
    end while (!accepted && budget > 0);
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL send_timeout got none want accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 1'b1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, N*16'(valid_out), '0);
    check({tag, "_flat"}, x_flat, '0);
    check({tag, "_max"}, N*16'(max_x), '0);
    check({tag, "_len"}, N*16'(row_len), '0);
  endtask

  // Monitor: every pulse must match the oldest expected row
  always @(negedge clk) begin
    if (rst === 1'b1 && valid_out === 1'b1) begin
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL pulse_width got 2 consecutive want 1");
      end
      if (exp_flat_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse got pulse want none");
      end else begin
        check("pulse_flat", x_flat, exp_flat_q.pop_front());
        check("pulse_max", N*16'(max_x), N*16'(exp_max_q.pop_front()));
        check("pulse_len", N*16'(row_len), N*16'(exp_len_q.pop_front()));
      end
      pulse_count++;
      prev_pulse_cyc = pulse_cyc;
      pulse_cyc = cyc;
    end
    prev_valid = (valid_out === 1'b1);
  end

  initial begin
    int p0;
    logic [15:0] row1 [8] = '{16'h0100, 16'hFF00, 16'h0280, 16'h0000,
                              16'hFE00, 16'h0040, 16'h0200, 16'h0010};
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = 16'h0000; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // full row, in_valid held
    for (int i = 0; i < 8; i++) send(row1[i], 1'b0);
    idle(2);

    // short row with in_last
    send(16'hFF00, 1'b0); send(16'hFE80, 1'b0); send(16'hFF80, 1'b1);
    idle(2);

    // stall mid-row and during ISSUE
    for (int i = 0; i < 4; i++) send(16'h0100 + 16'(i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h7777, 1'b0, 1'b0);
    for (int i = 4; i < 8; i++) send(16'hF000 + 16'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b0);
    idle(2);

    // asynchronous reset after 5 elements
    for (int i = 0; i < 5; i++) send(16'h7F00, 1'b0);
    #2 rst = 1'b0;
    #1 check_zero_outputs("midreset");
    row_q.delete(); model_issue = 1'b0;
    last_flat = '0; last_max = 16'h0000; last_len = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send(16'hFF00 - 16'(i * 16), 1'b0);
    idle(2);

    // back-to-back rows: in_valid stays high across the issue bubble
    p0 = pulse_count;
    for (int i = 0; i < 16; i++) send(16'(i * 37), 1'b0);
    idle(2);
    check("b2b_pulses", N*16'(pulse_count - p0), N*16'(2));
    check("b2b_spacing", N*16'(pulse_cyc - prev_pulse_cyc), N*16'(9));

    // single most-negative element
    send(16'h8000, 1'b1);
    idle(2);

    // randomized rows with random stalls and gaps
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) != 0));
    end
    idle(3);

    check("scoreboard_empty", N*16'(exp_flat_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
